// File: rtl/bcd_decade_counter.sv
// Single-digit BCD decade counter with up/down count, synchronous load,
// clock-enable prescaler and carry/borrow cascading. {a,b,c,d} feeds the
// BCD-to-decimal decoder directly (a = MSB).
module bcd_decade_counter #(
   parameter int unsigned DIV = 1,
   parameter int unsigned PW  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       cin,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] din,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       tc,
   output logic       co,
   output logic       load_err
);

   logic [3:0]    cnt;
   logic [3:0]    cnt_next;
   logic [PW-1:0] presc;
   logic          run;
   logic          step;
   logic          load_ok;

   assign run     = en & cin;
   assign step    = run & (presc == PW'(DIV - 1));
   assign load_ok = (din <= 4'd9);

   // Next count value for a step; out-of-range codes recover to 0 either way
   always_comb begin
      cnt_next = '0;
      if (cnt > 4'd9) begin
         cnt_next = '0;
      end else if (up) begin
         cnt_next = (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
      end else begin
         cnt_next = (cnt == 4'd0) ? 4'd9 : cnt - 4'd1;
      end
   end

   // Count, prescaler and load-error registers; load beats step beats hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         presc    <= '0;
         load_err <= 1'b0;
      end else begin
         load_err <= 1'b0;
         if (load) begin
            if (load_ok) begin
               cnt   <= din;
               presc <= '0;
            end else begin
               load_err <= 1'b1;
            end
         end else if (step) begin
            cnt   <= cnt_next;
            presc <= '0;
         end else if (run) begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Terminal count, cascade output and decoder-facing bit outputs
   always_comb begin
      tc = (up & (cnt == 4'd9)) | (~up & (cnt == 4'd0));
      co = step & tc & ~load & rst_n;
      a  = cnt[3];
      b  = cnt[2];
      c  = cnt[1];
      d  = cnt[0];
   end

endmodule

// File: tb/tb_bcd_decade_counter.sv
// Directed self-checking bench for bcd_decade_counter: DIV=1 digit, DIV=4
// digit, and a two-digit cascade with one-hot decoders on each digit.
module tb_bcd_decade_counter;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // DIV=1 digit
   logic       en1, cin1, up1, load1;
   logic [3:0] din1;
   logic       a1, b1, c1, d1, tc1, co1, le1;
   logic [3:0] q1;
   assign q1 = {a1, b1, c1, d1};

   bcd_decade_counter #(.DIV(1), .PW(16)) u_div1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .cin(cin1), .up(up1), .load(load1),
      .din(din1), .a(a1), .b(b1), .c(c1), .d(d1), .tc(tc1), .co(co1),
      .load_err(le1)
   );

   // DIV=4 digit
   logic       en4, cin4, up4, load4;
   logic [3:0] din4;
   logic       a4, b4, c4, d4, tc4, co4, le4;
   logic [3:0] q4;
   assign q4 = {a4, b4, c4, d4};

   bcd_decade_counter #(.DIV(4), .PW(3)) u_div4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .cin(cin4), .up(up4), .load(load4),
      .din(din4), .a(a4), .b(b4), .c(c4), .d(d4), .tc(tc4), .co(co4),
      .load_err(le4)
   );

   // Two-digit cascade: lo.co -> hi.cin
   logic       en_c;
   logic       a_lo, b_lo, c_lo, d_lo, tc_lo, co_lo, le_lo;
   logic       a_hi, b_hi, c_hi, d_hi, tc_hi, co_hi, le_hi;
   logic [3:0] q_lo, q_hi;
   logic [9:0] dec_lo, dec_hi;
   assign q_lo   = {a_lo, b_lo, c_lo, d_lo};
   assign q_hi   = {a_hi, b_hi, c_hi, d_hi};
   assign dec_lo = 10'd1 << q_lo;
   assign dec_hi = 10'd1 << q_hi;

   bcd_decade_counter #(.DIV(1), .PW(16)) u_lo (
      .clk(clk), .rst_n(rst_n), .en(en_c), .cin(1'b1), .up(1'b1), .load(1'b0),
      .din(4'd0), .a(a_lo), .b(b_lo), .c(c_lo), .d(d_lo), .tc(tc_lo),
      .co(co_lo), .load_err(le_lo)
   );

   bcd_decade_counter #(.DIV(1), .PW(16)) u_hi (
      .clk(clk), .rst_n(rst_n), .en(en_c), .cin(co_lo), .up(1'b1), .load(1'b0),
      .din(4'd0), .a(a_hi), .b(b_hi), .c(c_hi), .d(d_hi), .tc(tc_hi),
      .co(co_hi), .load_err(le_hi)
   );

   // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en1 = 1'b1; cin1 = 1'b1; up1 = 1'b1; load1 = 1'b0; din1 = 4'd0;
      en4 = 1'b0; cin4 = 1'b1; up4 = 1'b1; load4 = 1'b0; din4 = 4'd0;
      en_c = 1'b0;
      #2;
      checks++;
      if (q1 !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", q1); end
      checks++;
      if (co1 !== 1'b0) begin errors++; $display("FAIL reset_co: got %b expected 0", co1); end
      checks++;
      if (le1 !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b expected 0", le1); end
      tick();
      checks++;
      if (q1 !== 4'd0) begin errors++; $display("FAIL reset_hold: got %0d expected 0", q1); end
      rst_n = 1'b1;
   endtask

   task automatic test_count_up();
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (q1 !== 4'(i % 10)) begin
            errors++; $display("FAIL up_cnt[%0d]: got %0d expected %0d", i, q1, i % 10);
         end
         checks++;
         if (co1 !== ((i % 10) == 9)) begin
            errors++; $display("FAIL up_co[%0d]: got %b expected %b", i, co1, (i % 10) == 9);
         end
         tick();
      end
      checks++;
      if (q1 !== 4'd2) begin errors++; $display("FAIL up_end: got %0d expected 2", q1); end
   endtask

   task automatic test_count_down();
      rst_n = 1'b0;
      up1   = 1'b0;
      #1;
      checks++;
      if (co1 !== 1'b0) begin errors++; $display("FAIL dn_co_in_reset: got %b expected 0", co1); end
      checks++;
      if (q1 !== 4'd0) begin errors++; $display("FAIL dn_reset_cnt: got %0d expected 0", q1); end
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (tc1 !== 1'b1) begin errors++; $display("FAIL dn_tc0: got %b expected 1", tc1); end
      checks++;
      if (co1 !== 1'b1) begin errors++; $display("FAIL dn_co0: got %b expected 1", co1); end
      tick();
      checks++;
      if (q1 !== 4'd9) begin errors++; $display("FAIL dn_9: got %0d expected 9", q1); end
      checks++;
      if (tc1 !== 1'b0 || co1 !== 1'b0) begin
         errors++; $display("FAIL dn_tc_co_at9: got tc=%b co=%b expected 0 0", tc1, co1);
      end
      tick();
      checks++;
      if (q1 !== 4'd8) begin errors++; $display("FAIL dn_8: got %0d expected 8", q1); end
      tick();
      checks++;
      if (q1 !== 4'd7) begin errors++; $display("FAIL dn_7: got %0d expected 7", q1); end
   endtask

   task automatic test_load();
      // Load while counting down from 7: load wins over the step
      load1 = 1'b1; din1 = 4'd5;
      tick();
      checks++;
      if (q1 !== 4'd5) begin errors++; $display("FAIL load_over_step: got %0d expected 5", q1); end
      din1 = 4'd7;
      tick();
      checks++;
      if (q1 !== 4'd7 || le1 !== 1'b0) begin
         errors++; $display("FAIL load_7: got %0d err=%b expected 7 err=0", q1, le1);
      end
      din1 = 4'd12;
      tick();
      checks++;
      if (q1 !== 4'd7 || le1 !== 1'b1) begin
         errors++; $display("FAIL load_12_rej: got %0d err=%b expected 7 err=1", q1, le1);
      end
      din1 = 4'd10;
      tick();
      checks++;
      if (q1 !== 4'd7 || le1 !== 1'b1) begin
         errors++; $display("FAIL load_10_rej: got %0d err=%b expected 7 err=1", q1, le1);
      end
      load1 = 1'b0; en1 = 1'b0;
      tick();
      checks++;
      if (q1 !== 4'd7 || le1 !== 1'b0) begin
         errors++; $display("FAIL load_err_clear: got %0d err=%b expected 7 err=0", q1, le1);
      end
      // Load ignores en/cin; 9 is the largest legal value
      load1 = 1'b1; din1 = 4'd9; cin1 = 1'b0;
      tick();
      checks++;
      if (q1 !== 4'd9 || le1 !== 1'b0) begin
         errors++; $display("FAIL load_9: got %0d err=%b expected 9 err=0", q1, le1);
      end
      // At 9 counting up with a load pending, co is suppressed
      en1 = 1'b1; cin1 = 1'b1; up1 = 1'b1; din1 = 4'd2;
      #1;
      checks++;
      if (tc1 !== 1'b1 || co1 !== 1'b0) begin
         errors++; $display("FAIL load_co_block: got tc=%b co=%b expected 1 0", tc1, co1);
      end
      tick();
      checks++;
      if (q1 !== 4'd2) begin errors++; $display("FAIL load_2: got %0d expected 2", q1); end
      load1 = 1'b0;
      tick();
      checks++;
      if (q1 !== 4'd3) begin errors++; $display("FAIL after_load_step: got %0d expected 3", q1); end
   endtask

   task automatic test_prescaler();
      logic [3:0] exp4;
      en4 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp4 = 4'(k / 4);
         checks++;
         if (q4 !== exp4) begin
            errors++; $display("FAIL presc_cnt[%0d]: got %0d expected %0d", k, q4, exp4);
         end
      end
      tick(); tick();
      en4 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (q4 !== 4'd2) begin
            errors++; $display("FAIL presc_freeze[%0d]: got %0d expected 2", k, q4);
         end
      end
      en4 = 1'b1;
      tick();
      checks++;
      if (q4 !== 4'd2) begin errors++; $display("FAIL presc_resume1: got %0d expected 2", q4); end
      tick();
      checks++;
      if (q4 !== 4'd3) begin errors++; $display("FAIL presc_resume2: got %0d expected 3", q4); end
      // co only in the fourth cycle after a load to 9
      load4 = 1'b1; din4 = 4'd9;
      tick();
      load4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (co4 !== (k == 3)) begin
            errors++; $display("FAIL presc_co[%0d]: got %b expected %b", k, co4, k == 3);
         end
         tick();
      end
      checks++;
      if (q4 !== 4'd0) begin errors++; $display("FAIL presc_wrap: got %0d expected 0", q4); end
      en4 = 1'b0;
   endtask

   task automatic test_async_reset();
      load1 = 1'b1; din1 = 4'd0;
      tick();
      load1 = 1'b0; en1 = 1'b1; cin1 = 1'b1; up1 = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if (q1 !== 4'd6) begin errors++; $display("FAIL ar_six: got %0d expected 6", q1); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (q1 !== 4'd0) begin errors++; $display("FAIL ar_immediate: got %0d expected 0", q1); end
      tick();
      checks++;
      if (q1 !== 4'd0) begin errors++; $display("FAIL ar_hold1: got %0d expected 0", q1); end
      tick();
      checks++;
      if (q1 !== 4'd0) begin errors++; $display("FAIL ar_hold2: got %0d expected 0", q1); end
      rst_n = 1'b1;
      tick();
      checks++;
      if (q1 !== 4'd1) begin errors++; $display("FAIL ar_resume1: got %0d expected 1", q1); end
      tick();
      checks++;
      if (q1 !== 4'd2) begin errors++; $display("FAIL ar_resume2: got %0d expected 2", q1); end
   endtask

   task automatic test_cascade();
      logic [9:0] exp_lo, exp_hi;
      en_c = 1'b1;
      #1;
      for (int i = 0; i <= 100; i++) begin
         exp_lo = 10'd1 << ((i % 100) % 10);
         exp_hi = 10'd1 << ((i % 100) / 10);
         checks++;
         if (dec_lo !== exp_lo || dec_hi !== exp_hi) begin
            errors++;
            $display("FAIL cascade[%0d]: got hi=%0d lo=%0d dec=%b/%b expected %0d%0d",
                     i, q_hi, q_lo, dec_hi, dec_lo, (i % 100) / 10, i % 10);
         end
         if (i < 100) tick();
      end
      en_c = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_prescaler();
      test_async_reset();
      test_cascade();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
